div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 154 +++++++++++++++
 tb/tb_div_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider (signed DIV / unsigned DIVU).
//
// A request is taken from IDLE when validIn is high. The operand magnitudes are
// divided with one shift-subtract step per cycle for WIDTH cycles. The sign fix
// is then applied, and the result is registered into Lo (quotient) and Hi
// (remainder). validOut pulses for one cycle in DONE. Dropping validIn while
// busy abandons the divide and leaves Hi/Lo untouched.
//
// Ports:
//   clk       rising-edge clock for all state
//   resetn    asynchronous active-low reset
//   validIn   request; the initiator holds it high while it waits for the result
//   sign      1 = signed divide, 0 = unsigned (sampled at start only)
//   SrcA      dividend (sampled at start only)
//   SrcB      divisor (sampled at start only)
//   validOut  one-cycle result-valid pulse
//   Hi        remainder
//   Lo        quotient
//   busy      high while a divide is in progress (CALC and FIX)
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             validIn,
  input  logic             sign,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             validOut,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] dividend_raw;
  logic             neg_quot;
  logic             neg_rem;
  logic             div_zero;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quot_fixed;
  logic [WIDTH-1:0] rem_fixed;
  logic             last_iter;

  // The partial remainder always stays below the divisor. Because of that,
  // bit WIDTH of a WIDTH+1-bit difference is a valid borrow flag for the
  // restoring step.
  assign rem_shift  = {rem, quot[WIDTH-1]};
  assign diff       = rem_shift - {1'b0, divisor};
  assign last_iter  = (count == CW'(WIDTH - 1));
  assign quot_fixed = neg_quot ? -quot : quot;
  assign rem_fixed  = neg_rem  ? -rem  : rem;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs; losing validIn while busy aborts to IDLE
  always_comb begin
    state_next = state;
    validOut   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (validIn) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (!validIn)       state_next = IDLE;
        else if (last_iter) state_next = FIX;
      end
      FIX: begin
        busy = 1'b1;
        if (!validIn) state_next = IDLE;
        else          state_next = DONE;
      end
      DONE: begin
        validOut   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-subtract iterations, result write.
  // The quotient register starts out holding the dividend magnitude. Its
  // top bit is shifted into the remainder each step, and the new quotient
  // bit enters at the bottom.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count        <= '0;
      quot         <= '0;
      rem          <= '0;
      divisor      <= '0;
      dividend_raw <= '0;
      neg_quot     <= 1'b0;
      neg_rem      <= 1'b0;
      div_zero     <= 1'b0;
      Hi           <= '0;
      Lo           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (validIn) begin
            neg_quot     <= sign & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            neg_rem      <= sign & SrcA[WIDTH-1];
            div_zero     <= (SrcB == '0);
            dividend_raw <= SrcA;
            quot         <= (sign && SrcA[WIDTH-1]) ? -SrcA : SrcA;
            divisor      <= (sign && SrcB[WIDTH-1]) ? -SrcB : SrcB;
            rem          <= '0;
            count        <= '0;
          end
        end
        CALC: begin
          if (validIn) begin
            if (!diff[WIDTH]) begin
              rem  <= diff[WIDTH-1:0];
              quot <= {quot[WIDTH-2:0], 1'b1};
            end else begin
              rem  <= rem_shift[WIDTH-1:0];
              quot <= {quot[WIDTH-2:0], 1'b0};
            end
            count <= count + 1'b1;
          end
        end
        FIX: begin
          // Divide by zero gives an all-ones quotient and returns the
          // dividend exactly as it was presented, with no sign fix.
          if (validIn) begin
            Lo <= div_zero ? '1 : quot_fixed;
            Hi <= div_zero ? dividend_raw : rem_fixed;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed-vector bench for div_unit.
// The stimulus pushes the hand-computed quotient and remainder, together with
// the start cycle, into a scoreboard queue. A monitor pops one entry on every
// validOut pulse. It checks Lo, Hi, the latency, busy, and that the pulse lasts
// a single cycle.
module tb_div_unit;

  localparam int WIDTH   = 32;
  // validOut is first seen high after the 33rd edge following the start edge
  // (34 edges counting the start edge itself).
  localparam int LATENCY = 33;

  logic             clk = 1'b0;
  logic             resetn;
  logic             validIn;
  logic             sign;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             validOut;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             busy;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          start;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests    = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          prev_valid = 1'b0;
  logic [31:0] last_hi  = '0;
  logic [31:0] last_lo  = '0;

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .validIn  (validIn),
    .sign     (sign),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .validOut (validOut),
    .Hi       (Hi),
    .Lo       (Lo),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
    end
  endtask

  // Monitor: compare every presented result against the scoreboard head
  always @(negedge clk) begin
    if (resetn === 1'b1 && validOut === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL unexpected_validOut: got pulse with Lo=0x%08h Hi=0x%08h, expected none", Lo, Hi);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("Lo", Lo, mon_e.lo);
        checkOutput("Hi", Hi, mon_e.hi);
        checkOutput("latency", 32'(cyc - mon_e.start), 32'(LATENCY));
        checkOutput("busy_in_done", {31'b0, busy}, 32'd0);
        checkOutput("pulse_single_cycle", {31'b0, prev_valid}, 32'd0);
        last_hi = mon_e.hi;
        last_lo = mon_e.lo;
      end
    end
    prev_valid = (validOut === 1'b1);
  end

  // Start a divide: drive operands in IDLE, wait for the start edge, then
  // scramble the inputs to show they are no longer sampled.
  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                               input bit track);
    exp_t t;
    @(negedge clk);
    sign    = s;
    SrcA    = a;
    SrcB    = b;
    validIn = 1'b1;
    @(posedge clk);
    #1;
    if (track) begin
      t.hi    = exp_hi;
      t.lo    = exp_lo;
      t.start = cyc;
      sb.push_back(t);
    end
    sign = ~s;
    SrcA = ~a;
    SrcB = b + 32'd3;
  endtask

  task automatic waitPulse(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (validOut === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      failures++;
      $display("[TB] FAIL result_timeout: got no validOut within 100 cycles, expected a pulse");
    end
  endtask

  task automatic runOne(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    bit seen;
    applyStimulus(s, a, b, exp_lo, exp_hi, 1'b1);
    @(negedge clk);
    checkOutput("busy_calc", {31'b0, busy}, 32'd1);
    waitPulse(seen);
    validIn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    bit seen;
    resetn  = 1'b0;
    validIn = 1'b0;
    sign    = 1'b0;
    SrcA    = '0;
    SrcB    = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_Hi", Hi, 32'd0);
    checkOutput("reset_Lo", Lo, 32'd0);
    checkOutput("reset_validOut", {31'b0, validOut}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    resetn = 1'b1;

    // Directed vectors: sign, SrcA, SrcB, expected Lo, expected Hi
    runOne(1'b0, 32'd100,        32'd7,        32'd14,         32'd2);
    runOne(1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,   32'hFFFFFFFF);
    runOne(1'b0, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC,   32'd1);
    runOne(1'b0, 32'h12345678,   32'd0,        32'hFFFFFFFF,   32'h12345678);
    runOne(1'b1, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF,   32'hFFFFFFF9);
    runOne(1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,   32'd0);
    runOne(1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,   32'd1);
    runOne(1'b0, 32'd5,          32'd7,        32'd0,          32'd5);
    runOne(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,         32'hFFFFFFFE);

    // Abort: drop validIn mid-calculation; no result, outputs unchanged
    applyStimulus(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("abort_busy_before", {31'b0, busy}, 32'd1);
    validIn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_idle_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_Hi_kept", Hi, last_hi);
    checkOutput("abort_Lo_kept", Lo, last_lo);
    repeat (40) @(negedge clk);
    checkOutput("abort_Hi_later", Hi, last_hi);
    checkOutput("abort_Lo_later", Lo, last_lo);
    runOne(1'b0, 32'd50, 32'd5, 32'd10, 32'd0);

    // Back-to-back: validIn stays high; the second divide starts two edges
    // after the first pulse and captures the operands present at that time.
    begin
      exp_t t;
      @(negedge clk);
      sign    = 1'b0;
      SrcA    = 32'hFFFFFFFF;
      SrcB    = 32'h10;
      validIn = 1'b1;
      @(posedge clk);
      #1;
      t.hi = 32'hF;  t.lo = 32'h0FFFFFFF; t.start = cyc;      sb.push_back(t);
      t.hi = 32'd0;  t.lo = 32'd3;        t.start = cyc + 35; sb.push_back(t);
      SrcA = 32'd9;
      SrcB = 32'd3;
      waitPulse(seen);
      waitPulse(seen);
      validIn = 1'b0;
    end

    // Reset in the middle of a divide, then a fresh request
    applyStimulus(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("midreset_Hi", Hi, 32'd0);
    checkOutput("midreset_Lo", Lo, 32'd0);
    checkOutput("midreset_validOut", {31'b0, validOut}, 32'd0);
    checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
    validIn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    runOne(1'b0, 32'd81, 32'd9, 32'd9, 32'd0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
